// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the DRAM port arbiter.
// Holds the FSM state encoding, the requester grant IDs, the statistics
// counter width and the round-robin winner selection helper.
package mem_arbiter_pkg;

    localparam int unsigned STAT_W = 32;
    localparam int unsigned DATA_W = 32;

    // FSM state encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Requester IDs
    localparam logic [0:0] GRANT_I = 1'b0;
    localparam logic [0:0] GRANT_D = 1'b1;

    // Round-robin pick: a lone requester wins; on a tie the one not
    // granted last time wins.
    function automatic logic [0:0] rr_pick(input logic       pend_i,
                                           input logic       pend_d,
                                           input logic [0:0] last_grant);
        logic [0:0] win;
        win = GRANT_I;
        if (pend_i && pend_d) begin
            win = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
        end else if (pend_d) begin
            win = GRANT_D;
        end
        return win;
    endfunction

endpackage

// File: rtl/mem_arb_req_latch.sv
// Pending-request latch for one arbiter requester.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   set             request pulse; captures addr/we/wdata
//   clr             completion delivered for this requester
//   addr/we/wdata   request payload sampled with set
//   pend            request outstanding or pending
//   q_addr/q_we/q_wdata  captured payload
// A set on the clearing edge re-arms the latch with the new payload;
// a set while already pending (and not clearing) is dropped.
module mem_arb_req_latch #(
    parameter int unsigned MEM_SCALE = 27,
    parameter int unsigned DW        = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set,
    input  logic                 clr,
    input  logic [MEM_SCALE-1:0] addr,
    input  logic                 we,
    input  logic [DW-1:0]        wdata,
    output logic                 pend,
    output logic [MEM_SCALE-1:0] q_addr,
    output logic                 q_we,
    output logic [DW-1:0]        q_wdata
);

    logic capture_c;

    // Accept a pulse when free or when this very edge frees the latch.
    assign capture_c = set & (~pend | clr);

    always_ff @(posedge clk) begin
        if (rst) begin
            pend    <= 1'b0;
            q_addr  <= '0;
            q_we    <= 1'b0;
            q_wdata <= '0;
        end else if (capture_c) begin
            pend    <= 1'b1;
            q_addr  <= addr;
            q_we    <= we;
            q_wdata <= wdata;
        end else if (clr) begin
            pend    <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the DRAM port between the icache miss path
// and the dcache miss/writeback path.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_oe, i_addr                  icache read request pulse + address
//   i_rdata, i_valid              icache read data and completion pulse
//   d_oe, d_we, d_addr, d_wdata   dcache request pulse + payload
//   d_rdata, d_valid              dcache read data and completion pulse
//   m_oe, m_we, m_addr, m_wdata   DRAM command (m_oe is a one-cycle pulse)
//   m_rdata, m_valid              DRAM read data and completion pulse
//   busy                          transaction outstanding or pending
//   arb_cnt_i, arb_cnt_d          grants issued per requester
//   arb_cnt_stall                 cycles with an unserved pending request
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_SCALE = 27
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_oe,
    input  logic [MEM_SCALE-1:0] i_addr,
    output logic [DATA_W-1:0]    i_rdata,
    output logic                 i_valid,
    input  logic                 d_oe,
    input  logic                 d_we,
    input  logic [MEM_SCALE-1:0] d_addr,
    input  logic [DATA_W-1:0]    d_wdata,
    output logic [DATA_W-1:0]    d_rdata,
    output logic                 d_valid,
    output logic                 m_oe,
    output logic                 m_we,
    output logic [MEM_SCALE-1:0] m_addr,
    output logic [DATA_W-1:0]    m_wdata,
    input  logic [DATA_W-1:0]    m_rdata,
    input  logic                 m_valid,
    output logic                 busy,
    output logic [STAT_W-1:0]    arb_cnt_i,
    output logic [STAT_W-1:0]    arb_cnt_d,
    output logic [STAT_W-1:0]    arb_cnt_stall
);

    logic [0:0] state_q, state_d;
    logic [0:0] grant_q, grant_d;
    logic [0:0] last_grant_q, last_grant_d;

    logic                 pend_i, pend_d;
    logic [MEM_SCALE-1:0] i_q_addr, d_q_addr;
    logic                 i_q_we, d_q_we;
    logic [DATA_W-1:0]    i_q_wdata, d_q_wdata;

    logic                 issue_c;
    logic                 done_c;
    logic [0:0]           win_c;
    logic [MEM_SCALE-1:0] sel_addr_c;
    logic                 sel_we_c;
    logic [DATA_W-1:0]    sel_wdata_c;
    logic                 in_wait_c;
    logic                 serve_i_c, serve_d_c;
    logic                 stall_c;
    logic                 clr_i_c, clr_d_c;

    // Pending latches; the icache path never writes.
    mem_arb_req_latch #(.MEM_SCALE(MEM_SCALE), .DW(DATA_W)) u_latch_i (
        .clk     (clk),
        .rst     (rst),
        .set     (i_oe),
        .clr     (clr_i_c),
        .addr    (i_addr),
        .we      (1'b0),
        .wdata   ('0),
        .pend    (pend_i),
        .q_addr  (i_q_addr),
        .q_we    (i_q_we),
        .q_wdata (i_q_wdata)
    );

    mem_arb_req_latch #(.MEM_SCALE(MEM_SCALE), .DW(DATA_W)) u_latch_d (
        .clk     (clk),
        .rst     (rst),
        .set     (d_oe),
        .clr     (clr_d_c),
        .addr    (d_addr),
        .we      (d_we),
        .wdata   (d_wdata),
        .pend    (pend_d),
        .q_addr  (d_q_addr),
        .q_we    (d_q_we),
        .q_wdata (d_q_wdata)
    );

    // Winner payload mux
    always_comb begin
        win_c       = rr_pick(pend_i, pend_d, last_grant_q);
        sel_addr_c  = (win_c == GRANT_I) ? i_q_addr  : d_q_addr;
        sel_we_c    = (win_c == GRANT_I) ? i_q_we    : d_q_we;
        sel_wdata_c = (win_c == GRANT_I) ? i_q_wdata : d_q_wdata;
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        issue_c      = 1'b0;
        done_c       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_i || pend_d) begin
                    issue_c = 1'b1;
                    grant_d = win_c;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (m_valid) begin
                    done_c       = 1'b1;
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Completion routing and stall detection
    assign in_wait_c = (state_q == ST_WAIT);
    assign serve_i_c = in_wait_c & (grant_q == GRANT_I);
    assign serve_d_c = in_wait_c & (grant_q == GRANT_D);
    assign clr_i_c   = done_c & (grant_q == GRANT_I);
    assign clr_d_c   = done_c & (grant_q == GRANT_D);
    assign stall_c   = (pend_i & ~serve_i_c) | (pend_d & ~serve_d_c);

    assign i_valid = m_valid & serve_i_c;
    assign d_valid = m_valid & serve_d_c;
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;
    assign busy    = in_wait_c | pend_i | pend_d;

    // State, DRAM command and statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= GRANT_I;
            last_grant_q  <= GRANT_D;
            m_oe          <= 1'b0;
            m_we          <= 1'b0;
            m_addr        <= '0;
            m_wdata       <= '0;
            arb_cnt_i     <= '0;
            arb_cnt_d     <= '0;
            arb_cnt_stall <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            m_oe         <= issue_c;
            if (issue_c) begin
                m_addr  <= sel_addr_c;
                m_we    <= sel_we_c;
                m_wdata <= sel_wdata_c;
                if (win_c == GRANT_I) begin
                    arb_cnt_i <= arb_cnt_i + STAT_W'(1);
                end else begin
                    arb_cnt_d <= arb_cnt_d + STAT_W'(1);
                end
            end
            if (stall_c) begin
                arb_cnt_stall <= arb_cnt_stall + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a
// cycle-level reference model of the arbitration rules.
module tb_mem_arbiter;

    localparam int unsigned AW = 27;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_oe;
    logic [AW-1:0] i_addr;
    logic [31:0]   i_rdata;
    logic          i_valid;
    logic          d_oe;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic [31:0]   d_rdata;
    logic          d_valid;
    logic          m_oe;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic [31:0]   m_rdata;
    logic          m_valid;
    logic          busy;
    logic [31:0]   arb_cnt_i;
    logic [31:0]   arb_cnt_d;
    logic [31:0]   arb_cnt_stall;

    mem_arbiter #(.MEM_SCALE(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_oe          (i_oe),
        .i_addr        (i_addr),
        .i_rdata       (i_rdata),
        .i_valid       (i_valid),
        .d_oe          (d_oe),
        .d_we          (d_we),
        .d_addr        (d_addr),
        .d_wdata       (d_wdata),
        .d_rdata       (d_rdata),
        .d_valid       (d_valid),
        .m_oe          (m_oe),
        .m_we          (m_we),
        .m_addr        (m_addr),
        .m_wdata       (m_wdata),
        .m_rdata       (m_rdata),
        .m_valid       (m_valid),
        .busy          (busy),
        .arb_cnt_i     (arb_cnt_i),
        .arb_cnt_d     (arb_cnt_d),
        .arb_cnt_stall (arb_cnt_stall)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: pending requests, the one outstanding DRAM command,
    // who was served last, and the expected registered outputs.
    bit            mp_i, mp_d, out, who, lw, out_we;
    logic [AW-1:0] ma_i, ma_d;
    bit            mwe_d;
    logic [31:0]   mwd_d;
    bit            e_moe, e_mwe;
    logic [AW-1:0] e_maddr;
    logic [31:0]   e_mwd;
    logic [31:0]   ci, cd, cs;

    // DRAM responder and scenario controls
    int  lat      = -1;
    int  dram_L   = 0;
    bit  fix_en   = 0;
    bit  spur     = 0;
    bit  auto_rep = 0;
    int  pulses   = 0;
    bit  d_rep1   = 0;
    int  cyc      = 0;

    // Observation logs of DUT behaviour
    logic [AW-1:0] moe_addr[$];
    bit            moe_we[$];
    logic [31:0]   moe_wd[$];
    int            moe_cyc[$];
    int            iv_cnt, dv_cnt, iv_cyc;
    logic [31:0]   iv_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clr_logs();
        moe_addr.delete();
        moe_we.delete();
        moe_wd.delete();
        moe_cyc.delete();
        iv_cnt = 0;
        dv_cnt = 0;
        iv_cyc = -1;
        iv_data = '0;
    endtask

    task automatic model_edge();
        bit clr_i, clr_d, g;
        if (rst) begin
            mp_i = 0; mp_d = 0; out = 0; who = 0; lw = 1; out_we = 0;
            e_moe = 0; e_mwe = 0; e_maddr = '0; e_mwd = '0;
            ci = 0; cd = 0; cs = 0;
            return;
        end
        if ((mp_i && !(out && who == 0)) || (mp_d && !(out && who == 1))) cs++;
        clr_i = out && m_valid && who == 0;
        clr_d = out && m_valid && who == 1;
        e_moe = 0;
        if (out && m_valid) begin
            lw  = who;
            out = 0;
        end else if (!out && (mp_i || mp_d)) begin
            g = (mp_i && mp_d) ? !lw : mp_d;
            e_moe = 1;
            out   = 1;
            who   = g;
            if (g == 0) begin
                e_maddr = ma_i; e_mwe = 0; e_mwd = '0; ci++;
            end else begin
                e_maddr = ma_d; e_mwe = mwe_d; e_mwd = mwd_d; cd++;
            end
            out_we = e_mwe;
        end
        if (i_oe && (!mp_i || clr_i)) begin
            mp_i = 1; ma_i = i_addr;
        end else if (clr_i) mp_i = 0;
        if (d_oe && (!mp_d || clr_d)) begin
            mp_d = 1; ma_d = d_addr; mwe_d = d_we; mwd_d = d_wdata;
        end else if (clr_d) mp_d = 0;
    endtask

    task automatic check_cycle();
        bit e_iv, e_dv;
        e_iv = out && who == 0 && m_valid;
        e_dv = out && who == 1 && m_valid;
        chk("m_oe", m_oe, e_moe);
        chk("m_addr", m_addr, e_maddr);
        chk("m_we", m_we, e_mwe);
        chk("m_wdata", m_wdata, e_mwd);
        chk("i_valid", i_valid, e_iv);
        chk("d_valid", d_valid, e_dv);
        chk("busy", busy, out | mp_i | mp_d);
        chk("cnt_i", arb_cnt_i, ci);
        chk("cnt_d", arb_cnt_d, cd);
        chk("cnt_stall", arb_cnt_stall, cs);
        if (e_iv) chk("i_rdata", i_rdata, m_rdata);
        if (e_dv && !out_we) chk("d_rdata", d_rdata, m_rdata);
        if (m_oe === 1'b1) begin
            moe_addr.push_back(m_addr);
            moe_we.push_back(m_we);
            moe_wd.push_back(m_wdata);
            moe_cyc.push_back(cyc);
        end
        if (i_valid === 1'b1) begin
            iv_cnt++; iv_cyc = cyc; iv_data = i_rdata;
        end
        if (d_valid === 1'b1) dv_cnt++;
    endtask

    // One clock cycle: responder drive, check mid-cycle, edge, model update.
    task automatic tick();
        if (auto_rep && lat == 0 && out && pulses < 20) begin
            if (who == 0) begin
                i_oe = 1; i_addr = AW'(32'h100 + 32'(pulses));
            end else begin
                d_oe = 1; d_we = 1; d_addr = AW'(32'h200 + 32'(pulses)); d_wdata = $urandom;
            end
            pulses++;
        end
        if (d_rep1 && lat == 0 && out && who == 1) begin
            d_oe = 1; d_we = 0; d_addr = AW'(32'h3AA); d_rep1 = 0;
        end
        m_rdata = fix_en ? 32'hDEADBEEF : $urandom;
        m_valid = (lat == 0) || spur;
        #1;
        check_cycle();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        i_oe = 0;
        d_oe = 0;
        if (e_moe) lat = (dram_L != 0) ? dram_L : int'($urandom_range(1, 5));
        else if (lat >= 0) lat--;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
        clr_logs();
    endtask

    int n0;

    initial begin
        rst = 1; i_oe = 0; d_oe = 0; d_we = 0; i_addr = '0; d_addr = '0;
        d_wdata = '0; m_rdata = '0; m_valid = 0;
        clr_logs();
        repeat (2) @(posedge clk);
        model_edge();
        #1;
        do_reset();
        chk("rst_m_oe", m_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt_stall", arb_cnt_stall, 0);

        // Single icache read, DRAM latency 4
        dram_L = 4; fix_en = 1;
        i_oe = 1; i_addr = AW'(32'h123);
        tick();
        n0 = cyc;
        repeat (8) tick();
        chk("t1_moe_count", moe_addr.size(), 1);
        chk("t1_moe_lat", moe_cyc[0] - n0, 1);
        chk("t1_addr", moe_addr[0], 32'h123);
        chk("t1_we", moe_we[0], 0);
        chk("t1_iv_lat", iv_cyc - moe_cyc[0], 4);
        chk("t1_rdata", iv_data, 32'hDEADBEEF);
        chk("t1_cnt_i", arb_cnt_i, 1);
        chk("t1_stall", arb_cnt_stall, 1);
        fix_en = 0; dram_L = 0;

        // Simultaneous requests after reset: I first, then the D write
        do_reset();
        i_oe = 1; i_addr = AW'(32'h10);
        d_oe = 1; d_we = 1; d_addr = AW'(32'h40); d_wdata = 32'h55;
        tick();
        n0 = cyc;
        repeat (16) tick();
        chk("t2_moe_count", moe_addr.size(), 2);
        chk("t2_first_addr", moe_addr[0], 32'h10);
        chk("t2_d_addr", moe_addr[1], 32'h40);
        chk("t2_d_we", moe_we[1], 1);
        chk("t2_d_wdata", moe_wd[1], 32'h55);
        chk("t2_gap", moe_cyc[1] - iv_cyc, 2);
        chk("t2_dv_count", dv_cnt, 1);
        chk("t2_stall", arb_cnt_stall, 32'(moe_cyc[1] - n0));

        // Continuous alternating pressure
        do_reset();
        i_oe = 1; i_addr = AW'(32'h100);
        d_oe = 1; d_we = 1; d_addr = AW'(32'h201); d_wdata = $urandom;
        pulses = 2; auto_rep = 1;
        tick();
        for (int k = 0; k < 600; k++) begin
            if (pulses >= 20 && busy === 1'b0 && lat < 0) break;
            tick();
        end
        auto_rep = 0;
        chk("t3_drain", busy, 0);
        chk("t3_moe_count", moe_addr.size(), 20);
        for (int k = 0; k < moe_addr.size(); k++) begin
            logic [AW-1:0] a;
            a = moe_addr[k];
            chk("t3_alt", a[9:8], (k % 2 == 0) ? 1 : 2);
        end
        chk("t3_cnt_i", arb_cnt_i, 10);
        chk("t3_cnt_d", arb_cnt_d, 10);

        // D re-pulses on the edge of its own completion
        do_reset();
        d_oe = 1; d_we = 0; d_addr = AW'(32'h300); d_rep1 = 1;
        tick();
        repeat (16) tick();
        chk("t4_moe_count", moe_addr.size(), 2);
        chk("t4_first_addr", moe_addr[0], 32'h300);
        chk("t4_second_addr", moe_addr[1], 32'h3AA);
        chk("t4_dv_count", dv_cnt, 2);
        chk("t4_cnt_d", arb_cnt_d, 2);

        // Reset while waiting on DRAM; the late completion must be ignored
        do_reset();
        dram_L = 4;
        i_oe = 1; i_addr = AW'(32'h55);
        tick();
        tick();
        chk("t5_moe", m_oe, 1);
        rst = 1;
        tick();
        rst = 0;
        clr_logs();
        repeat (6) tick();
        dram_L = 0;
        chk("t5_iv", iv_cnt, 0);
        chk("t5_dv", dv_cnt, 0);
        chk("t5_busy", busy, 0);
        chk("t5_moe_count", moe_addr.size(), 0);
        chk("t5_cnt_i", arb_cnt_i, 0);
        chk("t5_cnt_stall", arb_cnt_stall, 0);

        // Spurious DRAM completion in IDLE
        clr_logs();
        spur = 1;
        tick();
        spur = 0;
        repeat (3) tick();
        chk("t6_iv", iv_cnt, 0);
        chk("t6_dv", dv_cnt, 0);
        chk("t6_busy", busy, 0);
        chk("t6_moe_count", moe_addr.size(), 0);

        // Random traffic, including pulses while already pending
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                i_oe = 1; i_addr = AW'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                d_oe = 1; d_we = 1'($urandom); d_addr = AW'($urandom); d_wdata = $urandom;
            end
            tick();
        end
        repeat (40) tick();
        chk("rand_drain", busy, 0);
        chk("rand_grants", arb_cnt_i + arb_cnt_d, 32'(moe_addr.size()));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single DRAM port between the instruction-cache miss path and the data-cache miss/writeback path.
- Each cache raises a one-cycle request pulse and waits for a one-cycle valid pulse. The arbiter latches requests, grants one at a time round-robin, forwards it to DRAM, and routes the completion back.
- Sits between the ICACHE/DCACHE super ports and the DRAM controller. Exposes grant/stall counters for the stat block.

Parameters:
MEM_SCALE, 27, word-address width shared with caches and DRAM.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
i_oe  input  1  icache read request pulse
i_addr  input  MEM_SCALE  icache word address, sampled when i_oe=1
i_rdata  output  32  read data to icache
i_valid  output  1  icache completion pulse
d_oe  input  1  dcache request pulse
d_we  input  1  with d_oe: 1=write, 0=read
d_addr  input  MEM_SCALE  dcache word address, sampled when d_oe=1
d_wdata  input  32  write data, sampled when d_oe=1
d_rdata  output  32  read data to dcache
d_valid  output  1  dcache completion pulse (reads and writes)
m_oe  output  1  DRAM command pulse
m_we  output  1  DRAM write enable, qualified by m_oe
m_addr  output  MEM_SCALE  DRAM address
m_wdata  output  32  DRAM write data
m_rdata  input  32  DRAM read data
m_valid  input  1  DRAM completion pulse
busy  output  1  a transaction is outstanding or pending
arb_cnt_i  output  32  icache grants
arb_cnt_d  output  32  dcache grants
arb_cnt_stall  output  32  cycles with a pending request not being served

Behaviour:
- Pending latches, one per requester:
  - Set on the request pulse; capture address (plus we/wdata for d).
  - Cleared when that requester's completion is delivered.
  - A pulse on the same edge as the clear re-sets the latch with the new data (set wins).
  - A pulse while the latch is already set is a protocol violation. It is ignored and the original request is kept.
- FSM states IDLE, WAIT.
- IDLE, neither latch set: m_oe=0.
- IDLE, any latch set: select the winner.
  - Only one set: that requester wins.
  - Both set: the requester not granted last time wins. last_grant resets to D, so I wins the first tie.
  - Register m_oe=1 for exactly one cycle, with m_addr/m_we/m_wdata from the winner's latch. Record grant. Go to WAIT.
  - Minimum latency: pulse at edge N, latch set at N, m_oe high in cycle N+1.
- WAIT:
  - m_addr/m_we/m_wdata hold stable; m_oe=0.
  - On m_valid: assert the granted requester's valid combinationally in the same cycle (i_valid = m_valid & WAIT & grant==I; D likewise).
  - On that edge: clear the granted latch, update last_grant, return to IDLE.
  - The next grant issues no earlier than the cycle after IDLE is entered, so back-to-back commands are at least 2 cycles apart.
- i_rdata and d_rdata both equal m_rdata at all times; they are only meaningful under their valid.
- A d write completes with d_valid on m_valid; d_rdata is don't-care.
- m_valid in IDLE is ignored.
- Only one m_oe is ever outstanding.
- Counters:
  - arb_cnt_i / arb_cnt_d +1 per m_oe issued for that requester.
  - arb_cnt_stall +1 per cycle where a latch is set but its requester is not in WAIT with grant; counts per cycle, not per requester.
  - 32-bit, wrap modulo 2^32.
- busy = WAIT | pend_i | pend_d.
- Reset (including mid-transaction):
  - IDLE, both latches cleared, last_grant=D.
  - m_oe=0, m_we=0, m_addr=0, m_wdata=0, i_valid=d_valid=0, counters=0.
  - An m_valid arriving after reset is ignored.
  - Request pulses coincident with rst are dropped.

Decomposition:
- Shared package:
  - state encoding ST_IDLE=0, ST_WAIT=1
  - grant IDs GRANT_I=0, GRANT_D=1
  - stat counter width 32
- Sub-module mem_arb_req_latch (params MEM_SCALE, DW): set/clear pending flag plus captured addr/we/wdata. Instantiated twice; the I instance ties we=0 and wdata=0.

Test Plan:
- Single i_oe addr=0x123 at cycle 5, DRAM m_valid 4 cycles after m_oe with 0xDEADBEEF -> m_oe cycle 6 with m_addr=0x123, m_we=0; i_valid cycle 10 with i_rdata=0xDEADBEEF; arb_cnt_i=1.
- i_oe and d_oe (write, addr 0x40, data 0x55) same cycle after reset -> I granted first; D issued with m_we=1, m_wdata=0x55 two cycles after I's m_valid; d_valid pulses once; arb_cnt_stall counts D's wait cycles.
- Continuous alternating pressure (each requester re-pulses on its own valid) -> grants strictly alternate I,D,I,D for 20 transactions; arb_cnt_i=arb_cnt_d=10.
- d_oe pulsed on the same edge as its own d_valid -> latch stays set with new addr; second m_oe issued for D when I is idle.
- rst asserted while in WAIT, late m_valid 2 cycles later -> no i_valid/d_valid; busy=0, all counters 0, m_oe stays 0.
- m_valid spuriously in IDLE with no requests -> no valid outputs, state unchanged.
